// File: rtl/trace_retire_buffer_pkg.sv
// Shared types for the retire-trace buffer; entries gain a timestamp word when
// TRACE_RETIRE_TIMESTAMP_EN is defined.
package trace_retire_buffer_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        valid;
  } trace_retire_outputs_t;

  typedef enum logic [1:0] {
    TRACE_PC    = 2'd0,
    TRACE_INSTR = 2'd1,
    TRACE_TS    = 2'd2
  } trace_beat_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
`ifdef TRACE_RETIRE_TIMESTAMP_EN
    logic [31:0] timestamp;
`endif
  } trace_entry_t;

  localparam int TRACE_ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/trace_retire_fifo.sv
// Flop-array FIFO with extra-MSB pointers; write visible on the next cycle, no fall-through.
// Caller may write while full only when it pops in the same cycle.
module trace_retire_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: empty gates every read-side use.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level   = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/trace_retire_buffer.sv
// Buffers retire trace beats and streams each entry as 32-bit words (pc, instr[, ts if TRACE_RETIRE_TIMESTAMP_EN]).
// First word one cycle after push; stream holds under !out_ready; retire is never stalled, overflow drops are counted.
module trace_retire_buffer
  import trace_retire_buffer_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DROP_CNT_W = 16,
  localparam int LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  trace_retire_outputs_t tr,
  output logic [31:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  input  logic                  clear,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_count,
  output logic [LVL_W-1:0]      level
);

`ifdef TRACE_RETIRE_TIMESTAMP_EN
  localparam trace_beat_t LAST_BEAT = TRACE_TS;
`else
  localparam trace_beat_t LAST_BEAT = TRACE_INSTR;
`endif

  trace_beat_t            beat_q, beat_d;
  trace_entry_t           wr_entry, head;
  logic                   full, empty, accept, pop, push, drop;
  logic [31:0]            data_mux;
  logic                   overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0]  drop_q, drop_d;

  assign wr_entry.pc          = tr.pc;
  assign wr_entry.instruction = tr.instruction;

`ifdef TRACE_RETIRE_TIMESTAMP_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc_q <= '0;
    else     cyc_q <= cyc_q + 32'd1;
  end

  assign wr_entry.timestamp = cyc_q;
`endif

  assign out_valid = !empty;
  assign accept    = out_valid && out_ready;
  assign out_last  = !empty && (beat_q == LAST_BEAT);
  assign pop       = accept && out_last;
  // A pop on the last beat frees the slot in time for a same-cycle push.
  assign push      = tr.valid && (!full || pop);
  assign drop      = tr.valid && full && !pop;

  trace_retire_fifo #(
    .WIDTH (TRACE_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) beat_q <= TRACE_PC;
    else     beat_q <= beat_d;
  end

  always_comb begin
    beat_d   = beat_q;
    data_mux = 32'h0;
    case (beat_q)
      TRACE_PC: begin
        data_mux = head.pc;
        if (accept) beat_d = TRACE_INSTR;
      end
      TRACE_INSTR: begin
        data_mux = head.instruction;
`ifdef TRACE_RETIRE_TIMESTAMP_EN
        if (accept) beat_d = TRACE_TS;
`else
        if (accept) beat_d = TRACE_PC;
`endif
      end
`ifdef TRACE_RETIRE_TIMESTAMP_EN
      TRACE_TS: begin
        data_mux = head.timestamp;
        if (accept) beat_d = TRACE_PC;
      end
`endif
      default: beat_d = TRACE_PC;
    endcase
  end

  assign out_data = empty ? 32'h0 : data_mux;

  // A drop in the clear cycle survives the clear.
  always_comb begin
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (clear) begin
      overflow_d = drop;
      drop_d     = drop ? DROP_CNT_W'(1) : '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != {DROP_CNT_W{1'b1}}) drop_d = drop_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_trace_retire_buffer.sv
// Bench for trace_retire_buffer: scoreboard of expected stream words plus a
// per-cycle vector table for the overflow fill and hand sequences for corners.
module tb_trace_retire_buffer;
  import trace_retire_buffer_pkg::*;

  localparam int DEPTH = 16;
  localparam int DW    = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef TRACE_RETIRE_TIMESTAMP_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  trace_retire_outputs_t tr;
  logic [31:0]           out_data;
  logic                  out_valid, out_ready, out_last, clear, overflow;
  logic [DW-1:0]         drop_count;
  logic [LW-1:0]         level;

  always #5 clk = ~clk;

  trace_retire_buffer #(.DEPTH(DEPTH), .DROP_CNT_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .tr         (tr),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .clear      (clear),
    .overflow   (overflow),
    .drop_count (drop_count),
    .level      (level)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;
  beat_t sb[$];

  int tb_cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cyc <= 0;
    else     tb_cyc <= tb_cyc + 1;
  end

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        rdy;
    logic        clr;
    logic        acc;
    int          lvl;
    logic        ovf;
    int          drp;
  } vec_t;
  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    tr.valid       = v;
    tr.pc          = pc;
    tr.instruction = ins;
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] ins);
    sb.push_back('{d: pc, l: 1'b0});
`ifdef TRACE_RETIRE_TIMESTAMP_EN
    sb.push_back('{d: ins, l: 1'b0});
    sb.push_back('{d: 32'(tb_cyc), l: 1'b1});
`else
    sb.push_back('{d: ins, l: 1'b1});
`endif
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      step();
      k++;
    end
    chk("drain_done", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got %h expected no beat", out_data);
      end else begin
        e = sb.pop_front();
        chk("sb_data", out_data, e.d);
        chk("sb_last", {31'b0, out_last}, {31'b0, e.l});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 20; i++) begin
      tbl[i].v   = 1'b1;
      tbl[i].pc  = 32'h0000_1000 + 32'(i * 4);
      tbl[i].rdy = 1'b0;
      tbl[i].clr = 1'b0;
      tbl[i].acc = (i < DEPTH);
      tbl[i].lvl = (i < DEPTH) ? i + 1 : DEPTH;
      tbl[i].ovf = (i >= DEPTH);
      tbl[i].drp = (i >= DEPTH) ? i - DEPTH + 1 : 0;
    end

    rst = 1'b1;
    retire(1'b0, 32'h0, 32'h0);
    out_ready = 1'b0;
    clear = 1'b0;
    #12;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_last", {31'b0, out_last}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Single retire with sink always ready
    out_ready = 1'b1;
    retire(1'b1, 32'h8000_0000, 32'h0000_0013);
    expect_entry(32'h8000_0000, 32'h0000_0013);
    step();
    retire(1'b0, 32'h0, 32'h0);
    chk("single_pc", out_data, 32'h8000_0000);
    chk("single_pc_last", {31'b0, out_last}, 32'd0);
    step();
    chk("single_instr", out_data, 32'h0000_0013);
    chk("single_instr_last", {31'b0, out_last}, (NB == 2) ? 32'd1 : 32'd0);
    wait_drain(10);
    chk("single_level", 32'(level), 32'd0);
    chk("single_valid", {31'b0, out_valid}, 32'd0);

    // Backpressure holds the first word stable
    out_ready = 1'b0;
    retire(1'b1, 32'h2000_0000, 32'h0000_0073);
    expect_entry(32'h2000_0000, 32'h0000_0073);
    step();
    retire(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_data", out_data, 32'h2000_0000);
      step();
    end
    out_ready = 1'b1;
    wait_drain(20);
    chk("bp_level", 32'(level), 32'd0);

    // Overflow fill from the vector table
    for (int i = 0; i < 20; i++) begin
      retire(tbl[i].v, tbl[i].pc, ~tbl[i].pc);
      out_ready = tbl[i].rdy;
      clear = tbl[i].clr;
      if (tbl[i].acc) expect_entry(tbl[i].pc, ~tbl[i].pc);
      step();
      chk("tbl_level", 32'(level), 32'(tbl[i].lvl));
      chk("tbl_overflow", {31'b0, overflow}, {31'b0, tbl[i].ovf});
      chk("tbl_drop", 32'(drop_count), 32'(tbl[i].drp));
    end
    retire(1'b0, 32'h0, 32'h0);

    // Full: pop of the last beat coincides with a new retire
    out_ready = 1'b1;
    repeat (NB - 1) step();
    retire(1'b1, 32'h0000_ABC0, 32'h1234_5678);
    expect_entry(32'h0000_ABC0, 32'h1234_5678);
    step();
    retire(1'b0, 32'h0, 32'h0);
    out_ready = 1'b0;
    chk("full_pp_level", 32'(level), 32'd16);
    chk("full_pp_drop", 32'(drop_count), 32'd4);
    out_ready = 1'b1;
    wait_drain(100);
    chk("full_pp_drained", 32'(level), 32'd0);

    // Saturation and clear
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      retire(1'b1, 32'h3000_0000 + 32'(i), 32'h0000_0100 + 32'(i));
      expect_entry(32'h3000_0000 + 32'(i), 32'h0000_0100 + 32'(i));
      step();
    end
    repeat (20) begin
      retire(1'b1, 32'hDEAD_0000, 32'h0);
      step();
    end
    retire(1'b0, 32'h0, 32'h0);
    chk("sat_drop", 32'(drop_count), 32'd15);
    chk("sat_overflow", {31'b0, overflow}, 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_drop", 32'(drop_count), 32'd0);
    chk("clr_overflow", {31'b0, overflow}, 32'd0);
    clear = 1'b1;
    retire(1'b1, 32'hDEAD_0001, 32'h0);
    step();
    clear = 1'b0;
    retire(1'b0, 32'h0, 32'h0);
    chk("clrdrop_drop", 32'(drop_count), 32'd1);
    chk("clrdrop_overflow", {31'b0, overflow}, 32'd1);
    chk("clrdrop_level", 32'(level), 32'd16);
    out_ready = 1'b1;
    wait_drain(200);
    out_ready = 1'b0;

    // Reset while the head entry is mid-stream
    for (int i = 0; i < 3; i++) begin
      retire(1'b1, 32'h4000_0000 + 32'(i), 32'h0000_0200 + 32'(i));
      expect_entry(32'h4000_0000 + 32'(i), 32'h0000_0200 + 32'(i));
      step();
    end
    retire(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("mid_instr_data", out_data, 32'h0000_0200);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_drop", 32'(drop_count), 32'd0);
    sb.delete();
    step();
    rst = 1'b0;
    step();
    retire(1'b1, 32'h5000_0000, 32'h0000_0300);
    expect_entry(32'h5000_0000, 32'h0000_0300);
    step();
    retire(1'b0, 32'h0, 32'h0);
    chk("post_rst_pc", out_data, 32'h5000_0000);
    chk("post_rst_last", {31'b0, out_last}, 32'd0);
    out_ready = 1'b1;
    wait_drain(20);
    chk("post_rst_level", 32'(level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
